// File: rtl/ipml_sync_fifo_v2.sv
// Single-clock FIFO with standard or first-word-fall-through reads, run-time
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module ipml_sync_fifo_v2 #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH_WIDTH = 10,
  parameter bit                    FWFT_EN     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RST_DATA    = {DATA_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_en,
  output logic                   rd_empty,
  output logic                   almost_empty,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int unsigned            NWORDS   = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   LVL_ZERO = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0]   LVL_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0]   LVL_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO = {DEPTH_WIDTH{1'b0}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]  mem_q [0:NWORDS-1];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   wr_full_q, wr_full_d, rd_empty_q, rd_empty_d;
  logic                   almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  logic                   overflow_q, overflow_d, underflow_q, underflow_d;
  logic                   wr_acc_s, rd_acc_s, bypass_s, ram_we_s, ram_re_s;

  // Accepted handshakes and RAM port enables; in FWFT the output register is the head slot
  always_comb begin
    wr_acc_s = wr_en & ~wr_full_q;
    rd_acc_s = rd_en & ~rd_empty_q;
    if (!flush && FWFT_EN) begin
      bypass_s = wr_acc_s & ((level_q == LVL_ZERO) | ((level_q == LVL_ONE) & rd_acc_s));
      ram_we_s = wr_acc_s & ~bypass_s;
      ram_re_s = rd_acc_s & (level_q > LVL_ONE);
    end else if (!flush) begin
      bypass_s = 1'b0;
      ram_we_s = wr_acc_s;
      ram_re_s = rd_acc_s;
    end else begin
      bypass_s = 1'b0;
      ram_we_s = 1'b0;
      ram_re_s = 1'b0;
    end
  end

  // Next-state: occupancy, pointers, output word and flags derived from the new level
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    rd_data_d      = rd_data_q;
    wr_full_d      = wr_full_q;
    rd_empty_d     = rd_empty_q;
    almost_full_d  = almost_full_q;
    almost_empty_d = almost_empty_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
    if (flush) begin
      wr_ptr_d       = PTR_ZERO;
      rd_ptr_d       = PTR_ZERO;
      level_d        = LVL_ZERO;
      rd_data_d      = RST_DATA;
      wr_full_d      = 1'b0;
      rd_empty_d     = 1'b1;
      almost_full_d  = 1'b0;
      almost_empty_d = 1'b1;
    end else begin
      level_d  = level_q + {{DEPTH_WIDTH{1'b0}}, wr_acc_s} - {{DEPTH_WIDTH{1'b0}}, rd_acc_s};
      wr_ptr_d = ram_we_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = ram_re_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      if (bypass_s) begin
        rd_data_d = wr_data;
      end else if (ram_re_s) begin
        rd_data_d = mem_q[rd_ptr_q];
      end else begin
        rd_data_d = rd_data_q;
      end
      wr_full_d      = (level_d == LVL_FULL);
      rd_empty_d     = (level_d == LVL_ZERO);
      almost_full_d  = (level_d >= af_thresh);
      almost_empty_d = (level_d <= ae_thresh);
      // A new error event in the clearing cycle wins over clr_err
      overflow_d     = (overflow_q & ~clr_err) | (wr_en & wr_full_q);
      underflow_d    = (underflow_q & ~clr_err) | (rd_en & rd_empty_q);
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= PTR_ZERO;
      rd_ptr_q       <= PTR_ZERO;
      level_q        <= LVL_ZERO;
      rd_data_q      <= RST_DATA;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      rd_data_q      <= rd_data_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage array is left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_full      = wr_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign rd_data      = rd_data_q;
  assign water_level  = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
